// File: rtl/ext_dma_pkg.sv
// rtl/ext_dma_pkg.sv - shared constants and helpers for the external DMA command dispatcher
package ext_dma_pkg;
  localparam int STS_INTERR = 4;
  localparam int STS_DECERR = 5;
  localparam int STS_SLVERR = 6;
  localparam int STS_OKAY   = 7;

  localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction
endpackage

// File: rtl/ext_dma_order_fifo.sv
// rtl/ext_dma_order_fifo.sv - channel-order FIFO with registered full/empty flags
module ext_dma_order_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          do_push, do_pop;

  // A push is refused whenever the registered full flag is set, even alongside a pop.
  always_comb begin
    do_push  = push && !full_q;
    do_pop   = pop && !empty_q;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
    full_d   = (cnt_d == CW'(DEPTH));
    empty_d  = (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
endmodule

// File: rtl/ext_dma_cmd_dispatch.sv
// rtl/ext_dma_cmd_dispatch.sv - routes commands to NUM_CH datamovers, merges status in command order
// Optional status error tracking: EXT_DMA_STS_ERR_EN
module ext_dma_cmd_dispatch
  import ext_dma_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CMD_W       = 104,
  parameter int STS_W       = 32,
  parameter int MAX_OUT     = 16,
  parameter int ORDER_DEPTH = 32
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic [CMD_W-1:0]        s_axis_cmd_tdata,
  input  logic [7:0]              s_axis_cmd_tdest,
  input  logic                    s_axis_cmd_tvalid,
  output logic                    s_axis_cmd_tready,
  output logic [NUM_CH*CMD_W-1:0] m_axis_cmd_tdata,
  output logic [NUM_CH-1:0]       m_axis_cmd_tvalid,
  input  logic [NUM_CH-1:0]       m_axis_cmd_tready,
  input  logic [NUM_CH*STS_W-1:0] s_axis_sts_tdata,
  input  logic [NUM_CH-1:0]       s_axis_sts_tvalid,
  output logic [NUM_CH-1:0]       s_axis_sts_tready,
  output logic [STS_W-1:0]        m_axis_sts_tdata,
  output logic                    m_axis_sts_tvalid,
  input  logic                    m_axis_sts_tready,
  output logic [STS_W/8-1:0]      m_axis_sts_tkeep,
  output logic                    m_axis_sts_tlast,
  output logic                    err_flag,
  output logic [15:0]             err_count
);
  localparam int         CH_W      = ch_width(NUM_CH);
  localparam logic [7:0] MAX_OUT_C = 8'(MAX_OUT);

  logic [CMD_W-1:0]  cmd_reg_q [NUM_CH];
  logic [CMD_W-1:0]  cmd_reg_d [NUM_CH];
  logic [NUM_CH-1:0] cmd_vld_q, cmd_vld_d;
  logic [7:0]        cnt_q [NUM_CH];
  logic [7:0]        cnt_d [NUM_CH];
  logic [STS_W-1:0]  sts_reg_q, sts_reg_d;
  logic              sts_vld_q, sts_vld_d;
  logic [STS_W-1:0]  sts_word [NUM_CH];
  logic [CH_W-1:0]   sel, head;
  logic              ord_full, ord_empty;
  logic              cmd_acc, sts_rdy, sts_acc;
  logic              unused_tdest;

  assign sel          = (NUM_CH == 1) ? '0 : s_axis_cmd_tdest[CH_W-1:0];
  assign unused_tdest = ^s_axis_cmd_tdest;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign m_axis_cmd_tdata[g*CMD_W +: CMD_W] = cmd_reg_q[g];
    assign sts_word[g]                        = s_axis_sts_tdata[g*STS_W +: STS_W];
  end

  // Ready is held low through reset; the ready-to-ready path via m_axis_cmd_tready is intentional.
  always_comb begin
    s_axis_cmd_tready = ap_rst_n && !ord_full && (cnt_q[sel] < MAX_OUT_C) &&
                        (!cmd_vld_q[sel] || m_axis_cmd_tready[sel]);
    cmd_acc           = s_axis_cmd_tvalid && s_axis_cmd_tready;
    sts_rdy           = !ord_empty && (!sts_vld_q || m_axis_sts_tready);
    s_axis_sts_tready = '0;
    s_axis_sts_tready[head] = sts_rdy;
    sts_acc           = sts_rdy && s_axis_sts_tvalid[head];

    for (int c = 0; c < NUM_CH; c++) begin
      cmd_reg_d[c] = cmd_reg_q[c];
      cmd_vld_d[c] = cmd_vld_q[c] && !m_axis_cmd_tready[c];
      cnt_d[c]     = cnt_q[c];
      if (cmd_acc && sel == CH_W'(c)) begin
        cmd_reg_d[c] = s_axis_cmd_tdata;
        cmd_vld_d[c] = 1'b1;
        cnt_d[c]     = cnt_d[c] + 8'd1;
      end
      if (sts_acc && head == CH_W'(c)) cnt_d[c] = cnt_d[c] - 8'd1;
    end

    sts_vld_d = sts_acc || (sts_vld_q && !m_axis_sts_tready);
    sts_reg_d = sts_acc ? sts_word[head] : sts_reg_q;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cmd_reg_q[c] <= '0;
        cnt_q[c]     <= '0;
      end
      cmd_vld_q <= '0;
      sts_reg_q <= '0;
      sts_vld_q <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        cmd_reg_q[c] <= cmd_reg_d[c];
        cnt_q[c]     <= cnt_d[c];
      end
      cmd_vld_q <= cmd_vld_d;
      sts_reg_q <= sts_reg_d;
      sts_vld_q <= sts_vld_d;
    end
  end

  ext_dma_order_fifo #(.W(CH_W), .DEPTH(ORDER_DEPTH)) u_order_fifo (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .push  (cmd_acc),
    .pop   (sts_acc),
    .wdata (sel),
    .rdata (head),
    .full  (ord_full),
    .empty (ord_empty)
  );

  assign m_axis_cmd_tvalid = cmd_vld_q;
  assign m_axis_sts_tdata  = sts_reg_q;
  assign m_axis_sts_tvalid = sts_vld_q;
  assign m_axis_sts_tkeep  = '1;
  assign m_axis_sts_tlast  = 1'b1;

`ifdef EXT_DMA_STS_ERR_EN
  logic        err_flag_q, err_flag_d;
  logic [15:0] err_count_q, err_count_d;
  logic        sts_err;

  always_comb begin
    sts_err     = sts_acc && (sts_word[head][STS_INTERR] || sts_word[head][STS_DECERR] ||
                              sts_word[head][STS_SLVERR]);
    err_flag_d  = err_flag_q || sts_err;
    err_count_d = err_count_q;
    if (sts_err && err_count_q != ERR_CNT_MAX) err_count_d = err_count_q + 16'd1;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      err_flag_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_flag_q  <= err_flag_d;
      err_count_q <= err_count_d;
    end
  end

  assign err_flag  = err_flag_q;
  assign err_count = err_count_q;
`else
  assign err_flag  = 1'b0;
  assign err_count = '0;
`endif
endmodule

// File: tb/tb_ext_dma_cmd_dispatch.sv
// tb/tb_ext_dma_cmd_dispatch.sv - scoreboard bench for ext_dma_cmd_dispatch (honours EXT_DMA_STS_ERR_EN)
module tb_ext_dma_cmd_dispatch;
  localparam int NUM_CH = 4, CMD_W = 32, STS_W = 8, MAX_OUT = 2, ORDER_DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst_n;
  logic [CMD_W-1:0]        cmd_tdata;
  logic [7:0]              cmd_tdest;
  logic                    cmd_tvalid, cmd_tready;
  logic [NUM_CH*CMD_W-1:0] m_cmd_tdata;
  logic [NUM_CH-1:0]       m_cmd_tvalid, m_cmd_tready;
  logic [NUM_CH*STS_W-1:0] s_sts_tdata;
  logic [NUM_CH-1:0]       s_sts_tvalid, s_sts_tready;
  logic [STS_W-1:0]        m_sts_tdata;
  logic                    m_sts_tvalid, m_sts_tready;
  logic [STS_W/8-1:0]      m_sts_tkeep;
  logic                    m_sts_tlast, err_flag;
  logic [15:0]             err_count;

  ext_dma_cmd_dispatch #(.NUM_CH(NUM_CH), .CMD_W(CMD_W), .STS_W(STS_W), .MAX_OUT(MAX_OUT),
                         .ORDER_DEPTH(ORDER_DEPTH)) dut (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .s_axis_cmd_tdata(cmd_tdata), .s_axis_cmd_tdest(cmd_tdest),
    .s_axis_cmd_tvalid(cmd_tvalid), .s_axis_cmd_tready(cmd_tready),
    .m_axis_cmd_tdata(m_cmd_tdata), .m_axis_cmd_tvalid(m_cmd_tvalid), .m_axis_cmd_tready(m_cmd_tready),
    .s_axis_sts_tdata(s_sts_tdata), .s_axis_sts_tvalid(s_sts_tvalid), .s_axis_sts_tready(s_sts_tready),
    .m_axis_sts_tdata(m_sts_tdata), .m_axis_sts_tvalid(m_sts_tvalid), .m_axis_sts_tready(m_sts_tready),
    .m_axis_sts_tkeep(m_sts_tkeep), .m_axis_sts_tlast(m_sts_tlast),
    .err_flag(err_flag), .err_count(err_count)
  );

  int n_checks = 0, n_fail = 0;
  logic [CMD_W-1:0] exp_cmd_q [NUM_CH][$];
  logic [STS_W-1:0] chan_sts_q [NUM_CH][$];
  logic [STS_W-1:0] exp_sts_q [$];
  int chan_got [NUM_CH];
  int chan_ret [NUM_CH];
  int err_model = 0;
  int dn_mode [NUM_CH];
  int sts_mode [NUM_CH];
  int mst_mode = 1;
  logic mon_en = 1'b0;
  logic [NUM_CH-1:0] prev_cv, prev_cr;
  logic [CMD_W-1:0]  prev_cd [NUM_CH];
  logic prev_sv = 1'b0, prev_sr = 1'b0;
  logic [STS_W-1:0] prev_sd = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic record(input int ch, input logic [CMD_W-1:0] d, input logic [STS_W-1:0] st);
    exp_cmd_q[ch].push_back(d);
    chan_sts_q[ch].push_back(st);
    exp_sts_q.push_back(st);
  endtask

  // Entered and left at posedge+2; upper tdest bits are randomised and must be ignored.
  task automatic send_cmd(input int ch, input logic [CMD_W-1:0] d, input logic [STS_W-1:0] st);
    int t = 0;
    cmd_tvalid = 1'b1;
    cmd_tdest  = {6'($urandom), 2'(ch)};
    cmd_tdata  = d;
    forever begin
      @(negedge clk);
      if (cmd_tready) begin
        record(ch, d, st);
        break;
      end
      if (++t > 100) begin
        n_checks++; n_fail++;
        $display("FAIL cmd_accept_timeout: ch %0d never accepted", ch);
        break;
      end
      step();
    end
    step();
    cmd_tvalid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    for (int c = 0; c < NUM_CH; c++) begin dn_mode[c] = 1; sts_mode[c] = 1; end
    mst_mode = 1;
    while (exp_sts_q.size() != 0 && t < 1000) begin step(); t++; end
    if (exp_sts_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: %0d statuses outstanding", exp_sts_q.size());
    end
    repeat (3) step();
  endtask

  // Datamover and status-sink models: inputs change only at posedge+2.
  always @(posedge clk) begin
    #2;
    for (int c = 0; c < NUM_CH; c++) begin
      m_cmd_tready[c] = (dn_mode[c] == 1) || (dn_mode[c] == 2 && 1'($urandom_range(0, 1)));
      s_sts_tvalid[c] = (chan_got[c] > chan_ret[c]) &&
                        ((sts_mode[c] == 1) || (sts_mode[c] == 2 && 1'($urandom_range(0, 1))));
      s_sts_tdata[c*STS_W +: STS_W] = s_sts_tvalid[c] ? chan_sts_q[c][0] : '0;
    end
    m_sts_tready = (mst_mode == 1) || (mst_mode == 2 && 1'($urandom_range(0, 1)));
  end

  // Monitor: negedge values equal those at the next posedge, so handshakes are judged here.
  always @(negedge clk) begin
    if (mon_en) begin
      check("sts_tready_onehot", 64'($countones(s_sts_tready) <= 1), 64'd1);
      for (int c = 0; c < NUM_CH; c++) begin
        if (prev_cv[c] && !prev_cr[c]) begin
          check("cmd_hold_vld", 64'(m_cmd_tvalid[c]), 64'd1);
          check("cmd_hold_data", 64'(m_cmd_tdata[c*CMD_W +: CMD_W]), 64'(prev_cd[c]));
        end
        if (m_cmd_tvalid[c] && m_cmd_tready[c]) begin
          if (exp_cmd_q[c].size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL cmd_unexpected: ch %0d data %0h", c, m_cmd_tdata[c*CMD_W +: CMD_W]);
          end else begin
            check("cmd_data", 64'(m_cmd_tdata[c*CMD_W +: CMD_W]), 64'(exp_cmd_q[c].pop_front()));
            chan_got[c]++;
          end
        end
        if (s_sts_tvalid[c] && s_sts_tready[c] && chan_sts_q[c].size() != 0) begin
          void'(chan_sts_q[c].pop_front());
          chan_ret[c]++;
        end
        prev_cd[c] = m_cmd_tdata[c*CMD_W +: CMD_W];
      end
      if (prev_sv && !prev_sr) begin
        check("sts_hold_vld", 64'(m_sts_tvalid), 64'd1);
        check("sts_hold_data", 64'(m_sts_tdata), 64'(prev_sd));
      end
      if (m_sts_tvalid && m_sts_tready) begin
        if (exp_sts_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL sts_unexpected: data %0h", m_sts_tdata);
        end else begin
          if (|exp_sts_q[0][6:4]) err_model++;
          check("sts_order", 64'(m_sts_tdata), 64'(exp_sts_q.pop_front()));
        end
      end
      prev_cv = m_cmd_tvalid; prev_cr = m_cmd_tready;
      prev_sv = m_sts_tvalid; prev_sr = m_sts_tready; prev_sd = m_sts_tdata;
    end else begin
      prev_cv = '0; prev_cr = '0; prev_sv = 1'b0; prev_sr = 1'b0;
    end
  end

  initial begin
    logic seen;
    int   t;
    rst_n = 1'b0; cmd_tvalid = 1'b0; cmd_tdata = '0; cmd_tdest = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      dn_mode[c] = 1; sts_mode[c] = 0; chan_got[c] = 0; chan_ret[c] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_tvalid", 64'(m_cmd_tvalid), 64'd0);
    check("rst_sts_tvalid", 64'(m_sts_tvalid), 64'd0);
    check("rst_cmd_tready", 64'(cmd_tready), 64'd0);
    check("rst_sts_tready", 64'(s_sts_tready), 64'd0);
    check("rst_cmd_data", 64'(m_cmd_tdata), 64'd0);
    check("rst_sts_data", 64'(m_sts_tdata), 64'd0);
    check("rst_err", {47'd0, err_flag, err_count}, 64'd0);
    step();
    rst_n = 1'b1; mon_en = 1'b1;
    step();
    check("sts_tkeep", 64'(m_sts_tkeep), 64'd1);
    check("sts_tlast", 64'(m_sts_tlast), 64'd1);

    // In-order merge: ch1 status waits behind ch0's first status.
    sts_mode[1] = 1;
    send_cmd(0, 32'h1000_0000, 8'h01);
    send_cmd(1, 32'h1000_0001, 8'h02);
    send_cmd(0, 32'h1000_0002, 8'h03);
    repeat (3) begin
      @(negedge clk);
      check("order_stall_sts_tvalid", 64'(m_sts_tvalid), 64'd0);
      check("order_stall_ch1_tready", 64'(s_sts_tready[1]), 64'd0);
      step();
    end
    drain();

    // Outstanding limit on one channel.
    for (int c = 0; c < NUM_CH; c++) sts_mode[c] = 0;
    send_cmd(1, 32'h2000_0000, 8'h04);
    send_cmd(1, 32'h2000_0001, 8'h05);
    cmd_tvalid = 1'b1; cmd_tdest = 8'h01; cmd_tdata = 32'h2000_0002;
    repeat (3) begin
      @(negedge clk);
      check("maxout_block", 64'(cmd_tready), 64'd0);
      step();
    end
    sts_mode[1] = 1;
    seen = 1'b0; t = 0;
    forever begin
      @(negedge clk);
      if (seen) begin
        check("maxout_release", 64'(cmd_tready), 64'd1);
        if (cmd_tready) record(1, 32'h2000_0002, 8'h06);
        break;
      end
      check("maxout_hold", 64'(cmd_tready), 64'd0);
      if (s_sts_tvalid[1] && s_sts_tready[1]) seen = 1'b1;
      if (++t > 50) begin check("maxout_sts_seen", 64'(seen), 64'd1); break; end
      step();
    end
    step();
    cmd_tvalid = 1'b0;
    drain();

    // Order FIFO full; a pop in the same cycle must not let a push through.
    for (int c = 0; c < NUM_CH; c++) sts_mode[c] = 0;
    for (int c = 0; c < NUM_CH; c++) send_cmd(c, 32'h3000_0000 + 32'(c), 8'(8'h10 + c));
    cmd_tvalid = 1'b1; cmd_tdest = 8'h00; cmd_tdata = 32'h3000_0004;
    repeat (2) begin
      @(negedge clk);
      check("fifo_full_block", 64'(cmd_tready), 64'd0);
      step();
    end
    sts_mode[0] = 1;
    seen = 1'b0; t = 0;
    forever begin
      @(negedge clk);
      if (seen) begin
        check("fifo_after_pop", 64'(cmd_tready), 64'd1);
        if (cmd_tready) record(0, 32'h3000_0004, 8'h14);
        break;
      end
      check("fifo_push_refused", 64'(cmd_tready), 64'd0);
      if (s_sts_tvalid[0] && s_sts_tready[0]) seen = 1'b1;
      if (++t > 50) begin check("fifo_pop_seen", 64'(seen), 64'd1); break; end
      step();
    end
    step();
    cmd_tvalid = 1'b0;
    drain();

    // Back-pressured channel holds its command while another channel proceeds.
    dn_mode[0] = 0;
    step();
    send_cmd(0, 32'hA5A5_0001, 8'h21);
    send_cmd(1, 32'h5A5A_0002, 8'h22);
    repeat (5) begin
      @(negedge clk);
      check("hold_vld", 64'(m_cmd_tvalid[0]), 64'd1);
      check("hold_data", 64'(m_cmd_tdata[CMD_W-1:0]), 64'h0000_0000_A5A5_0001);
      step();
    end
    drain();

    // Reset with commands outstanding.
    for (int c = 0; c < NUM_CH; c++) begin dn_mode[c] = 0; sts_mode[c] = 0; end
    step();
    for (int c = 0; c < 3; c++) send_cmd(c, 32'h4000_0000 + 32'(c), 8'h30);
    step();
    mon_en = 1'b0; rst_n = 1'b0;
    #1;
    check("midrst_cmd_tvalid", 64'(m_cmd_tvalid), 64'd0);
    check("midrst_sts_tvalid", 64'(m_sts_tvalid), 64'd0);
    check("midrst_cmd_tready", 64'(cmd_tready), 64'd0);
    check("midrst_sts_tready", 64'(s_sts_tready), 64'd0);
    for (int c = 0; c < NUM_CH; c++) begin
      exp_cmd_q[c].delete(); chan_sts_q[c].delete();
      chan_got[c] = 0; chan_ret[c] = 0; dn_mode[c] = 1;
    end
    exp_sts_q.delete();
    err_model = 0;
    repeat (2) step();
    rst_n = 1'b1; mon_en = 1'b1;
    step();
    cmd_tvalid = 1'b1; cmd_tdest = 8'h03; cmd_tdata = 32'h5000_0003;
    @(negedge clk);
    check("postrst_accept", 64'(cmd_tready), 64'd1);
    if (cmd_tready) record(3, 32'h5000_0003, 8'h00);
    step();
    cmd_tvalid = 1'b0;
    @(negedge clk);
    check("postrst_latency_vld", 64'(m_cmd_tvalid[3]), 64'd1);
    check("postrst_latency_data", 64'(m_cmd_tdata[3*CMD_W +: CMD_W]), 64'h0000_0000_5000_0003);
    step();
    send_cmd(2, 32'h5000_0010, 8'h00);
    send_cmd(2, 32'h5000_0011, 8'h00);
    drain();

    // Status error tracking: OKAY, SLVERR, DECERR.
    send_cmd(0, 32'h6000_0000, 8'h80);
    send_cmd(0, 32'h6000_0001, 8'h40);
    send_cmd(0, 32'h6000_0002, 8'h20);
    drain();
`ifdef EXT_DMA_STS_ERR_EN
    check("err_count_directed", 64'(err_count), 64'd2);
    check("err_flag_directed", 64'(err_flag), 64'd1);
`else
    check("err_count_directed", 64'(err_count), 64'd0);
    check("err_flag_directed", 64'(err_flag), 64'd0);
`endif

    // Randomised traffic with random back-pressure everywhere.
    for (int c = 0; c < NUM_CH; c++) begin dn_mode[c] = 2; sts_mode[c] = 2; end
    mst_mode = 2;
    for (int i = 0; i < 150; i++) begin
      send_cmd(int'($urandom_range(0, NUM_CH - 1)), $urandom, 8'($urandom));
      if ($urandom_range(0, 3) == 0) step();
    end
    drain();
`ifdef EXT_DMA_STS_ERR_EN
    check("err_count_final", 64'(err_count), 64'((err_model > 65535) ? 65535 : err_model));
    check("err_flag_final", 64'(err_flag), 64'(err_model != 0));
`else
    check("err_count_final", 64'(err_count), 64'd0);
    check("err_flag_final", 64'(err_flag), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ext_dma_cmd_dispatch.md
# ext_dma_cmd_dispatch

Parametrised command dispatcher and status merger for the external DMA plugin, placed between the CCLO-side command/status streams and NUM_CH independent datamover channels. Each incoming command is routed to a channel selected by its tdest, with per-channel outstanding-command limits. Channel status words are returned on a single status stream strictly in original command order. This generalises the fixed two-port DMA wrapper to any power-of-two channel count and adds ordering and flow control.

## Interface
- NUM_CH, 2: channels; power of two, 1..8; CH_W = max(1, log2(NUM_CH))
- CMD_W, 104: command word width
- STS_W, 32: status word width (8 for mm2s instances)
- MAX_OUT, 16: max outstanding commands per channel, 1..255
- ORDER_DEPTH, 32: order FIFO depth, power of two, >= 2
- ap_clk  in  1  clock
- ap_rst_n  in  1  asynchronous active-low reset
- s_axis_cmd_tdata  in  CMD_W  command
- s_axis_cmd_tdest  in  8  routing; channel = tdest[CH_W-1:0]
- s_axis_cmd_tvalid / s_axis_cmd_tready  in / out  1  handshake
- m_axis_cmd_tdata  out  NUM_CH*CMD_W  per-channel command, channel c at [c*CMD_W +: CMD_W]
- m_axis_cmd_tvalid / m_axis_cmd_tready  out / in  NUM_CH  per-channel handshake
- s_axis_sts_tdata  in  NUM_CH*STS_W  per-channel status
- s_axis_sts_tvalid / s_axis_sts_tready  in / out  NUM_CH
- m_axis_sts_tdata  out  STS_W  merged status
- m_axis_sts_tvalid / m_axis_sts_tready  out / in  1
- m_axis_sts_tkeep  out  STS_W/8  constant all ones
- m_axis_sts_tlast  out  1  constant 1
- err_flag  out  1  sticky status-error flag (see Configuration)
- err_count  out  16  saturating status-error count (see Configuration)

## Operation
- Command accept when s_axis_cmd_tvalid && s_axis_cmd_tready. tready = !ord_full && cnt[sel] < MAX_OUT && (!cmd_vld[sel] || m_axis_cmd_tready[sel]).
- On accept: load cmd_reg[sel], set cmd_vld[sel], push sel into order FIFO, cnt[sel]++.
- cmd_vld[c] clears on m_axis_cmd handshake unless reloaded in the same cycle.
- Order FIFO head h selects status source. s_axis_sts_tready[h] = !ord_empty && (!sts_vld || m_axis_sts_tready); all other s_axis_sts_tready are 0.
- On status accept: load sts_reg, set sts_vld, pop FIFO, cnt[h]--.
- Accept and status accept on the same channel in one cycle: cnt unchanged.
- Status from a channel other than the head is held upstream; no reordering buffer.
- Full FIFO: no push, even if a pop occurs in the same cycle; tready uses registered full.
- Empty FIFO: all s_axis_sts_tready are 0.
- Status error: |sts[6:4], i.e. the datamover INTERR/DECERR/SLVERR bits.

## Timing
- Reset values: all tvalid 0, all tready 0 in reset, cmd/sts data regs 0, cnt 0, FIFO empty, err_flag 0, err_count 0.
- Command latency: accept cycle to m_axis_cmd_tvalid is 1 cycle. Full throughput of 1 cmd/cycle when the downstream channel is ready.
- Status latency: accept cycle to m_axis_sts_tvalid is 1 cycle, 1/cycle throughput.
- s_axis_cmd_tready depends combinationally on m_axis_cmd_tready[sel] and tdest. This path is accepted and documented.
- Outputs hold stable while valid && !ready (AXIS rule).
- Reset mid-operation: all state is dropped immediately; in-flight commands are lost. Recovery is owned by the CCLO.

## Configuration
- EXT_DMA_STS_ERR_EN defined:
  - err_flag sets on the first accepted status with an error and clears only on reset.
  - err_count increments per errored status and saturates at 16'hFFFF.
- EXT_DMA_STS_ERR_EN undefined: err_flag and err_count are tied to 0 and no counter logic is built. Ports remain for interface stability.

## Structure
- ext_dma_pkg holds:
  - status error bit positions (STS_INTERR=4, STS_DECERR=5, STS_SLVERR=6, STS_OKAY=7)
  - a clog2-based CH_W helper
  - the 16-bit error counter max constant
- Sub-module ext_dma_order_fifo: sync FIFO, CH_W wide, ORDER_DEPTH deep, with registered full/empty and asynchronous active-low reset.

## Test plan
- NUM_CH=2: commands with tdest 0,1,0 and channels returning status in order 1,0,0 -> m_axis_sts emits ch0, ch1, ch0 words in command order. Channel 1's status is stalled until ch0's first status arrives.
- MAX_OUT=2: three commands with tdest=1 and no status returned -> third command sees s_axis_cmd_tready=0. One status accepted -> tready=1 on the next cycle.
- ORDER_DEPTH=4, commands to 4 channels, no status -> 5th command blocked. A pop and a push attempted in the same cycle -> push refused that cycle.
- m_axis_cmd_tready[0]=0 for 5 cycles -> cmd data and valid held stable. A command to ch1 is accepted meanwhile.
- With EXT_DMA_STS_ERR_EN: statuses 8'h80, 8'h40, 8'h20 -> err_count=2, err_flag=1. Without the macro -> both stay 0.
- Assert ap_rst_n low with 3 commands outstanding -> all valids 0 and cnt 0. After release, a fresh command routes with 1-cycle latency.
